// File: rtl/gold_nic_pkg.sv
// Shared constants and packet layout for the gold_nic ring network interface.
package gold_nic_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned VC_BIT = 63;

  localparam logic [1:0] ADDR_IBUF  = 2'b00;
  localparam logic [1:0] ADDR_ISTAT = 2'b01;
  localparam logic [1:0] ADDR_OBUF  = 2'b10;
  localparam logic [1:0] ADDR_OSTAT = 2'b11;

  typedef struct packed {
    logic        vc;
    logic        dir;
    logic [5:0]  rsvd;
    logic [7:0]  hop;
    logic [15:0] src;
    logic [31:0] payload;
  } pkt_t;

endpackage

// File: rtl/gold_nic_chbuf.sv
// Single-entry channel buffer: load fills an empty slot, drain empties it.
module gold_nic_chbuf #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_drain,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic [W-1:0] r_data;

  // A load into a full slot is dropped; contents survive a drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load && !r_full) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/gold_nic.sv
// Ring NIC: memory-mapped processor registers, one-entry in/out channel buffers.
module gold_nic #(
  parameter int unsigned DATA_W = gold_nic_pkg::DATA_W,
  parameter int unsigned VC_BIT = gold_nic_pkg::VC_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);
  import gold_nic_pkg::*;

  logic              w_wr;
  logic              w_rd;
  logic              w_obuf_load;
  logic              w_obuf_full;
  logic [DATA_W-1:0] w_obuf;
  logic              w_ibuf_load;
  logic              w_ibuf_drain;
  logic              w_ibuf_full;
  logic [DATA_W-1:0] w_ibuf;
  logic [DATA_W-1:0] w_d_out_d;
  logic [DATA_W-1:0] r_d_out;

  assign w_wr = nicEn & nicWrEn;
  assign w_rd = nicEn & ~nicWrEn;

  assign w_obuf_load = w_wr & (addr == ADDR_OBUF) & ~w_obuf_full;
  // Only inject when the packet's virtual channel matches this cycle's ring polarity.
  assign net_so      = w_obuf_full & net_ro & (w_obuf[VC_BIT] == net_polarity);
  assign net_do      = w_obuf;

  assign net_ri       = ~w_ibuf_full;
  assign w_ibuf_load  = net_si & net_ri;
  assign w_ibuf_drain = w_rd & (addr == ADDR_IBUF) & w_ibuf_full;

  gold_nic_chbuf #(
    .W (DATA_W)
  ) u_obuf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_obuf_load),
    .i_data  (d_in),
    .i_drain (net_so),
    .o_full  (w_obuf_full),
    .o_data  (w_obuf)
  );

  gold_nic_chbuf #(
    .W (DATA_W)
  ) u_ibuf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_ibuf_load),
    .i_data  (net_di),
    .i_drain (w_ibuf_drain),
    .o_full  (w_ibuf_full),
    .o_data  (w_ibuf)
  );

  always_comb begin
    w_d_out_d = '0;
    if (w_rd) begin
      case (addr)
        ADDR_IBUF:  w_d_out_d = w_ibuf;
        ADDR_ISTAT: w_d_out_d = {{(DATA_W-1){1'b0}}, w_ibuf_full};
        ADDR_OBUF:  w_d_out_d = w_obuf;
        ADDR_OSTAT: w_d_out_d = {{(DATA_W-1){1'b0}}, w_obuf_full};
        default:    w_d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_d_out <= '0;
    else       r_d_out <= w_d_out_d;
  end

  assign d_out = r_d_out;

endmodule

// File: tb/tb_gold_nic.sv
// Directed vector bench for gold_nic: register access, injection polarity, delivery.
module tb_gold_nic;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;

  int checks;
  int failures;

  gold_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic        en;
    logic        wr;
    logic [63:0] din;
    logic        ro;
    logic        pol;
    logic        si;
    logic [63:0] di;
    logic        exp_so;
    logic        exp_ri;
    logic [63:0] exp_do;
    logic [63:0] exp_dout;
  } vec_t;

  localparam logic [63:0] P1 = 64'h8000_0000_0000_0001;
  localparam logic [63:0] PD = 64'hDEAD_BEEF_0000_0003;

  localparam int NV = 37;
  vec_t vecs[NV];

  function automatic vec_t mk(logic [1:0] a, logic en, logic wr, logic [63:0] din, logic ro,
                              logic pol, logic si, logic [63:0] di, logic so, logic ri,
                              logic [63:0] dov, logic [63:0] dout);
    vec_t v;
    v.addr = a; v.en = en; v.wr = wr; v.din = din; v.ro = ro; v.pol = pol;
    v.si = si; v.di = di; v.exp_so = so; v.exp_ri = ri; v.exp_do = dov; v.exp_dout = dout;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    addr = v.addr; nicEn = v.en; nicWrEn = v.wr; d_in = v.din;
    net_ro = v.ro; net_polarity = v.pol; net_si = v.si; net_di = v.di;
  endtask

  task automatic step(int idx, vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk("net_so", idx, {63'b0, net_so}, {63'b0, v.exp_so});
    chk("net_ri", idx, {63'b0, net_ri}, {63'b0, v.exp_ri});
    chk("net_do", idx, net_do, v.exp_do);
    @(posedge clk);
    #1;
    chk("d_out", idx, d_out, v.exp_dout);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    drive(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    // addr en wr din ro pol si di | so ri do dout
    vecs[0]  = mk(2'b01, 1, 0, 0,        1, 0, 0, 0,      0, 1, 0,     0);
    vecs[1]  = mk(2'b11, 1, 0, 0,        1, 1, 0, 0,      0, 1, 0,     0);
    vecs[2]  = mk(2'b10, 1, 1, 64'hA5,   1, 1, 0, 0,      0, 1, 0,     0);
    vecs[3]  = mk(2'b00, 0, 0, 0,        1, 1, 0, 0,      0, 1, 64'hA5, 0);
    vecs[4]  = mk(2'b00, 0, 0, 0,        1, 0, 0, 0,      1, 1, 64'hA5, 0);
    vecs[5]  = mk(2'b11, 1, 0, 0,        1, 1, 0, 0,      0, 1, 64'hA5, 0);
    vecs[6]  = mk(2'b10, 1, 1, P1,       0, 1, 0, 0,      0, 1, 64'hA5, 0);
    vecs[7]  = mk(2'b00, 0, 0, 0,        0, 0, 0, 0,      0, 1, P1,    0);
    vecs[8]  = mk(2'b00, 0, 0, 0,        0, 1, 0, 0,      0, 1, P1,    0);
    vecs[9]  = mk(2'b00, 0, 0, 0,        0, 0, 0, 0,      0, 1, P1,    0);
    vecs[10] = mk(2'b00, 0, 0, 0,        0, 1, 0, 0,      0, 1, P1,    0);
    vecs[11] = mk(2'b10, 1, 1, 64'h2,    0, 0, 0, 0,      0, 1, P1,    0);
    vecs[12] = mk(2'b10, 1, 0, 0,        0, 1, 0, 0,      0, 1, P1,    P1);
    vecs[13] = mk(2'b11, 1, 0, 0,        0, 0, 0, 0,      0, 1, P1,    1);
    vecs[14] = mk(2'b00, 0, 0, 0,        1, 0, 0, 0,      0, 1, P1,    0);
    vecs[15] = mk(2'b00, 0, 0, 0,        1, 1, 0, 0,      1, 1, P1,    0);
    vecs[16] = mk(2'b11, 1, 0, 0,        1, 0, 0, 0,      0, 1, P1,    0);
    vecs[17] = mk(2'b00, 0, 0, 0,        1, 1, 1, PD,     0, 1, P1,    0);
    vecs[18] = mk(2'b01, 1, 0, 0,        1, 0, 0, 0,      0, 0, P1,    1);
    vecs[19] = mk(2'b00, 1, 0, 0,        1, 1, 0, 0,      0, 0, P1,    PD);
    vecs[20] = mk(2'b00, 0, 0, 0,        1, 0, 0, 0,      0, 1, P1,    0);
    vecs[21] = mk(2'b00, 0, 0, 0,        1, 1, 1, 64'h11, 0, 1, P1,    0);
    vecs[22] = mk(2'b00, 1, 0, 0,        1, 0, 1, 64'h22, 0, 0, P1,    64'h11);
    vecs[23] = mk(2'b00, 0, 0, 0,        1, 1, 1, 64'h22, 0, 1, P1,    0);
    vecs[24] = mk(2'b00, 1, 0, 0,        1, 0, 0, 0,      0, 0, P1,    64'h22);
    vecs[25] = mk(2'b00, 0, 0, 0,        1, 1, 0, 0,      0, 1, P1,    0);
    vecs[26] = mk(2'b00, 1, 0, 0,        1, 0, 0, 0,      0, 1, P1,    64'h22);
    vecs[27] = mk(2'b01, 1, 0, 0,        1, 1, 0, 0,      0, 1, P1,    0);
    vecs[28] = mk(2'b00, 1, 1, 64'hFF,   1, 0, 0, 0,      0, 1, P1,    0);
    vecs[29] = mk(2'b01, 1, 0, 0,        1, 1, 0, 0,      0, 1, P1,    0);
    vecs[30] = mk(2'b00, 1, 0, 0,        1, 0, 0, 0,      0, 1, P1,    64'h22);
    vecs[31] = mk(2'b11, 1, 1, 64'hFF,   1, 1, 0, 0,      0, 1, P1,    0);
    vecs[32] = mk(2'b11, 1, 0, 0,        1, 0, 0, 0,      0, 1, P1,    0);
    vecs[33] = mk(2'b10, 1, 1, 64'h4,    1, 1, 0, 0,      0, 1, P1,    0);
    // write on the transfer edge is dropped
    vecs[34] = mk(2'b10, 1, 1, 64'h6,    1, 0, 0, 0,      1, 1, 64'h4, 0);
    vecs[35] = mk(2'b11, 1, 0, 0,        1, 1, 0, 0,      0, 1, 64'h4, 0);
    vecs[36] = mk(2'b10, 1, 0, 0,        1, 0, 0, 0,      0, 1, 64'h4, 64'h4);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_d_out", 0, d_out, 64'h0);
    chk("rst_net_so", 0, {63'b0, net_so}, 64'h0);
    chk("rst_net_ri", 0, {63'b0, net_ri}, 64'h1);
    chk("rst_net_do", 0, net_do, 64'h0);

    for (int i = 0; i < NV; i++) step(i, vecs[i]);

    // Fill both buffers, then reset: contents and status must be lost.
    @(negedge clk);
    drive(mk(2'b10, 1, 1, 64'h5, 0, 0, 1, 64'h77, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre_rst_ri", 0, {63'b0, net_ri}, 64'h0);
    chk("pre_rst_do", 0, net_do, 64'h5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(mk(2'b11, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("post_rst_so", 0, {63'b0, net_so}, 64'h0);
    chk("post_rst_ri", 0, {63'b0, net_ri}, 64'h1);
    chk("post_rst_do", 0, net_do, 64'h0);
    @(posedge clk);
    #1;
    chk("post_rst_ostat", 0, d_out, 64'h0);
    @(negedge clk);
    addr = 2'b01;
    @(posedge clk);
    #1;
    chk("post_rst_istat", 0, d_out, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
